// File: rtl/cpu_run_pkg.sv
// cpu_run_pkg: shared state and stop-cause encodings for the CPU run controller
package cpu_run_pkg;
    typedef enum logic [1:0] {HOLD, WAIT, RUN, DONE} run_state_e;
    typedef enum logic [1:0] {
        STOP_NONE    = 2'b00,
        STOP_HALT    = 2'b01,
        STOP_IDLE    = 2'b10,
        STOP_TIMEOUT = 2'b11
    } stop_cause_e;
endpackage

// File: rtl/cpu_run_ctrl_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones, with synchronous clear
module sat_counter #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         CLR_N,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    always_ff @(posedge CLK or negedge CLR_N)
        if (!CLR_N) q <= '0;
        else if (clr) q <= '0;
        else if (inc && q != '1) q <= q + W'(1);
endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: sequences core reset/enable, counts run statistics and stops the core
// on halt address, idle PC or timeout.
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 32,
    parameter int RST_HOLD   = 2,
    parameter int HALT_ADDR  = 76,
    parameter int IDLE_LIMIT = 8,
    parameter int TIMEOUT    = 600
) (
    input  logic              CLK,
    input  logic              CLR_N,
    input  logic              Start,
    input  logic [ADDR_W-1:0] Addr,
    input  logic              stall,
    input  logic              condition_met,
    output logic              Core_Clr_N,
    output logic              Core_En,
    output logic              Done,
    output logic [1:0]        Status,
    output logic [CNT_W-1:0]  Cycle_Cnt,
    output logic [CNT_W-1:0]  Stall_Cnt,
    output logic [CNT_W-1:0]  Branch_Cnt
);
    localparam int IW = IDLE_LIMIT < 1 ? 1 : $clog2(IDLE_LIMIT + 1);
    // A timeout beyond the saturated cycle count can never match, so drop it outright
    localparam bit TO_EN = TIMEOUT != 0 && 64'(TIMEOUT) <= (64'd1 << CNT_W);

    run_state_e        state, state_nx;
    stop_cause_e       cause;
    logic [7:0]        hold_cnt;
    logic [IW-1:0]     idle_cnt, idle_nx;
    logic [ADDR_W-1:0] prev_pc;
    logic              hit_a, hit_b, hit_c, run, clr;

    always_comb begin
        state_nx = state;
        run      = state == RUN;
        clr      = state == DONE && Start;
        idle_nx  = (Addr == prev_pc && !stall) ? idle_cnt + IW'(1) : '0;
        hit_a    = Addr == ADDR_W'(HALT_ADDR);
        hit_b    = IDLE_LIMIT != 0 && idle_nx == IW'(IDLE_LIMIT);
        hit_c    = TO_EN && ({1'b0, Cycle_Cnt} + (CNT_W+1)'(1) == (CNT_W+1)'(TIMEOUT));
        cause    = hit_a ? STOP_HALT : hit_b ? STOP_IDLE : hit_c ? STOP_TIMEOUT : STOP_NONE;
        unique case (state)
            HOLD: state_nx = hold_cnt == 8'(RST_HOLD - 1) ? WAIT : HOLD;
            WAIT: state_nx = Start ? RUN : WAIT;
            RUN:  state_nx = cause != STOP_NONE ? DONE : RUN;
            DONE: state_nx = Start ? HOLD : DONE;
        endcase
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state      <= HOLD;
            hold_cnt   <= '0;
            idle_cnt   <= '0;
            prev_pc    <= '0;
            Status     <= STOP_NONE;
            Core_Clr_N <= 1'b0;
            Core_En    <= 1'b0;
            Done       <= 1'b0;
        end else begin
            state    <= state_nx;
            hold_cnt <= (state == HOLD && state_nx == HOLD) ? hold_cnt + 8'd1 : '0;
            idle_cnt <= run ? idle_nx : '0;
            if ((state == WAIT && Start) || run) prev_pc <= Addr;
            if (run && state_nx == DONE) Status <= cause;
            else if (clr) Status <= STOP_NONE;
            // Pin drivers follow the next state so they stay true flops
            Core_Clr_N <= state_nx != HOLD;
            Core_En    <= state_nx == RUN;
            Done       <= state_nx == DONE;
        end
    end

    sat_counter #(.W(CNT_W)) u_cycle (.CLK(CLK), .CLR_N(CLR_N), .clr(clr), .inc(run), .q(Cycle_Cnt));
    sat_counter #(.W(CNT_W)) u_stall (.CLK(CLK), .CLR_N(CLR_N), .clr(clr), .inc(run && stall), .q(Stall_Cnt));
    sat_counter #(.W(CNT_W)) u_branch (.CLK(CLK), .CLR_N(CLR_N), .clr(clr), .inc(run && condition_met), .q(Branch_Cnt));
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: three cpu_run_ctrl variants driven in lockstep and checked against
// a run-level model that predicts stop cycle, cause and counter totals per run.
module tb_cpu_run_ctrl;
    logic        CLK = 0, CLR_N = 1, Start = 0, stall = 0, condition_met = 0;
    logic [31:0] Addr = 0;
    int          checks = 0, errors = 0;

    wire [2:0]  cn, en, dn;
    wire [1:0]  st0, st1, st2;
    wire [31:0] cy0, sl0, br0, cy1, sl1, br1;
    wire [3:0]  cy2, sl2, br2;

    int to_p[3] = '{600, 20, 600};
    int w_p[3]  = '{32, 32, 4};

    logic [31:0] seq_a[$];
    bit          seq_s[$], seq_b[$];

    always #5 CLK = ~CLK;

    cpu_run_ctrl dut (.CLK(CLK), .CLR_N(CLR_N), .Start(Start), .Addr(Addr), .stall(stall),
        .condition_met(condition_met), .Core_Clr_N(cn[0]), .Core_En(en[0]), .Done(dn[0]),
        .Status(st0), .Cycle_Cnt(cy0), .Stall_Cnt(sl0), .Branch_Cnt(br0));
    cpu_run_ctrl #(.TIMEOUT(20)) dut_t (.CLK(CLK), .CLR_N(CLR_N), .Start(Start), .Addr(Addr),
        .stall(stall), .condition_met(condition_met), .Core_Clr_N(cn[1]), .Core_En(en[1]),
        .Done(dn[1]), .Status(st1), .Cycle_Cnt(cy1), .Stall_Cnt(sl1), .Branch_Cnt(br1));
    cpu_run_ctrl #(.CNT_W(4)) dut_s (.CLK(CLK), .CLR_N(CLR_N), .Start(Start), .Addr(Addr),
        .stall(stall), .condition_met(condition_met), .Core_Clr_N(cn[2]), .Core_En(en[2]),
        .Done(dn[2]), .Status(st2), .Cycle_Cnt(cy2), .Stall_Cnt(sl2), .Branch_Cnt(br2));

    function automatic logic [63:0] cyc_of(int k);
        return k == 0 ? 64'(cy0) : k == 1 ? 64'(cy1) : 64'(cy2);
    endfunction
    function automatic logic [63:0] stl_of(int k);
        return k == 0 ? 64'(sl0) : k == 1 ? 64'(sl1) : 64'(sl2);
    endfunction
    function automatic logic [63:0] brn_of(int k);
        return k == 0 ? 64'(br0) : k == 1 ? 64'(br1) : 64'(br2);
    endfunction
    function automatic logic [63:0] st_of(int k);
        return k == 0 ? 64'(st0) : k == 1 ? 64'(st1) : 64'(st2);
    endfunction
    function automatic logic [63:0] lmin(logic [63:0] a, logic [63:0] b);
        return a < b ? a : b;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(string tag, int k, logic e_cn, logic e_en, logic e_dn,
                           logic [63:0] e_st, logic [63:0] e_c, logic [63:0] e_s, logic [63:0] e_b);
        chk($sformatf("%s[%0d].core_clr_n", tag, k), 64'(cn[k]), 64'(e_cn));
        chk($sformatf("%s[%0d].core_en", tag, k), 64'(en[k]), 64'(e_en));
        chk($sformatf("%s[%0d].done", tag, k), 64'(dn[k]), 64'(e_dn));
        chk($sformatf("%s[%0d].status", tag, k), st_of(k), e_st);
        chk($sformatf("%s[%0d].cycles", tag, k), cyc_of(k), e_c);
        chk($sformatf("%s[%0d].stalls", tag, k), stl_of(k), e_s);
        chk($sformatf("%s[%0d].branches", tag, k), brn_of(k), e_b);
    endtask

    // Predict where a run over seq_* stops (1-based cycle), why, and the counter totals.
    function automatic void analyze(int k, logic [31:0] a0, output int n, output logic [1:0] cause,
                                    output logic [63:0] c, output logic [63:0] s, output logic [63:0] b);
        logic [63:0] mx = (64'd1 << w_p[k]) - 1;
        logic [31:0] prev = a0;
        int idle = 0;
        n = 0; cause = 0; s = 0; b = 0;
        for (int i = 0; i < seq_a.size() && n == 0; i++) begin
            idle = (seq_a[i] == prev && !seq_s[i]) ? idle + 1 : 0;
            prev = seq_a[i];
            s += 64'(seq_s[i]);
            b += 64'(seq_b[i]);
            cause = seq_a[i] == 76 ? 2'd1 : idle == 8 ? 2'd2 :
                    (to_p[k] != 0 && lmin(64'(i), mx) + 1 == 64'(to_p[k])) ? 2'd3 : 2'd0;
            if (cause != 0) n = i + 1;
        end
        c = lmin(64'(n), mx); s = lmin(s, mx); b = lmin(b, mx);
    endfunction

    task automatic push(logic [31:0] a, bit s, bit b);
        seq_a.push_back(a); seq_s.push_back(s); seq_b.push_back(b);
    endtask

    task automatic clear_seq();
        seq_a.delete(); seq_s.delete(); seq_b.delete();
    endtask

    task automatic do_run(string tag, logic [31:0] a0);
        int n[3];
        logic [1:0] cause[3];
        logic [63:0] c[3], s[3], b[3];
        for (int k = 0; k < 3; k++) analyze(k, a0, n[k], cause[k], c[k], s[k], b[k]);
        Addr = a0; Start = 1; stall = 0; condition_met = 0;
        @(negedge CLK);
        Start = 0;
        for (int i = 0; i < seq_a.size(); i++) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("%s[%0d].en@%0d", tag, k, i), 64'(en[k]), 64'(i < n[k]));
                chk($sformatf("%s[%0d].done@%0d", tag, k, i), 64'(dn[k]), 64'(i >= n[k]));
            end
            Addr = seq_a[i]; stall = seq_s[i]; condition_met = seq_b[i];
            @(negedge CLK);
        end
        stall = 0; condition_met = 0;
        for (int k = 0; k < 3; k++) chk_all(tag, k, 1, 0, 1, 64'(cause[k]), c[k], s[k], b[k]);
    endtask

    task automatic hold_then_wait(string tag);
        @(negedge CLK);
        for (int k = 0; k < 3; k++) chk_all({tag, ".hold1"}, k, 0, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        for (int k = 0; k < 3; k++) chk_all({tag, ".hold2"}, k, 0, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        for (int k = 0; k < 3; k++) chk_all({tag, ".wait"}, k, 1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic restart(string tag);
        Start = 1;
        hold_then_wait(tag);
        Start = 0;
        @(negedge CLK);
    endtask

    initial begin
        #1 CLR_N = 0;
        @(negedge CLK);
        @(negedge CLK);
        for (int k = 0; k < 3; k++) chk_all("reset", k, 0, 0, 0, 0, 0, 0, 0);
        CLR_N = 1;
        Start = 1;
        @(negedge CLK);
        for (int k = 0; k < 3; k++) chk_all("hold_a", k, 0, 0, 0, 0, 0, 0, 0);
        Start = 0;
        @(negedge CLK);
        for (int k = 0; k < 3; k++) chk_all("hold_b", k, 1, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge CLK);
        for (int k = 0; k < 3; k++) chk_all("wait_idle", k, 1, 0, 0, 0, 0, 0, 0);

        clear_seq();
        for (int i = 0; i < 20; i++) push(32'(4 * i), 0, 0);
        do_run("halt", 0);
        restart("restart1");

        clear_seq();
        repeat (5) push(40, 1, 0);
        repeat (10) push(40, 0, 0);
        push(76, 0, 0);
        do_run("idle", 40);
        restart("restart2");

        clear_seq();
        for (int i = 0; i < 12; i++)
            push(32'(200 + 4 * i), i == 1 || i == 2 || i == 5 || i == 9, i == 3 || i == 6 || i == 10);
        push(76, 0, 0);
        do_run("counters", 200);
        restart("restart3");

        clear_seq();
        for (int i = 0; i < 650; i++) push(32'(1000 + 4 * i), i % 7 == 0, i % 5 == 0);
        push(76, 0, 0);
        do_run("timeout", 1000);
        restart("restart4");

        for (int r = 0; r < 6; r++) begin
            logic [31:0] a;
            logic [31:0] a0;
            a0 = 32'(4 * $urandom_range(15, 21));
            a = a0;
            clear_seq();
            for (int i = 0; i < 30; i++) begin
                if ($urandom_range(7, 0) > r + 1) a = 32'(4 * $urandom_range(15, 21));
                push(a, $urandom_range(3, 0) == 0, $urandom_range(2, 0) == 0);
            end
            push(76, 0, 0);
            do_run($sformatf("rand%0d", r), a0);
            restart($sformatf("rrestart%0d", r));
        end

        Addr = 300; Start = 1;
        @(negedge CLK);
        Start = 0;
        for (int i = 0; i < 5; i++) begin
            Addr = 32'(304 + 4 * i); stall = i[0]; condition_met = 1;
            @(negedge CLK);
        end
        for (int k = 0; k < 3; k++) chk_all("midrun", k, 1, 1, 0, 0, 5, 2, 5);
        #2 CLR_N = 0;
        #1;
        for (int k = 0; k < 3; k++) chk_all("abort", k, 0, 0, 0, 0, 0, 0, 0);
        stall = 0; condition_met = 0;
        @(negedge CLK);
        CLR_N = 1;
        @(negedge CLK);
        for (int k = 0; k < 3; k++) chk_all("rehold", k, 0, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        for (int k = 0; k < 3; k++) chk_all("rewait", k, 1, 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Parametrised run controller and performance monitor for the pipelined CPU core.
- Sequences core reset and enable, then counts cycles, stall cycles and taken branches while the core runs.
- Detects end-of-program by halt address, idle PC or timeout, freezes the core and reports why.
- Sits between the top-level CLK/CLR_N and the core's CLR_N/EN pins, and replaces ad-hoc halt and finish logic in benches and the FPGA top.

Parameters:
- ADDR_W, 32, width of the observed PC (Addr).
- CNT_W, 32, width of each performance counter.
- RST_HOLD, 2, cycles Core_Clr_N is held low after each (re)start; legal range 1..255.
- HALT_ADDR, 76, PC value that ends the run.
- IDLE_LIMIT, 8, consecutive non-stalled cycles with unchanged PC that end the run; 0 disables the check.
- TIMEOUT, 600, maximum RUN cycles; 0 disables the check.

Ports:
- CLK  in  1  system clock, rising edge.
- CLR_N  in  1  asynchronous active-low reset.
- Start  in  1  single-cycle pulse; begins a run from WAIT, or restarts from DONE.
- Addr  in  ADDR_W  current core PC.
- stall  in  1  core hazard-stall indication.
- condition_met  in  1  core branch-taken indication.
- Core_Clr_N  out  1  registered reset to the core, active-low.
- Core_En  out  1  registered enable to the core.
- Done  out  1  run finished; sticky.
- Status  out  2  stop cause: 00 none, 01 halt address, 10 idle PC, 11 timeout.
- Cycle_Cnt  out  CNT_W  RUN cycles.
- Stall_Cnt  out  CNT_W  RUN cycles with stall=1.
- Branch_Cnt  out  CNT_W  RUN cycles with condition_met=1.

Behaviour:
- Reset (CLR_N=0, asynchronous):
  - state=HOLD, hold counter=0, idle counter=0.
  - Core_Clr_N=0, Core_En=0, Done=0, Status=00, all counters=0.
  - Reset applied mid-run aborts immediately; there is no partial-state retention.
- HOLD:
  - Core_Clr_N=0, Core_En=0.
  - Hold counter increments every cycle; after RST_HOLD cycles the state moves to WAIT.
  - Start is ignored in this state.
- WAIT:
  - Core_Clr_N=1, Core_En=0; the block waits for Start.
  - On the Start edge: state moves to RUN, Core_En=1 from the next cycle, and the previous-PC register loads Addr.
- RUN:
  - Core_Clr_N=1, Core_En=1.
  - Every edge: Cycle_Cnt+=1, Stall_Cnt+=stall, Branch_Cnt+=condition_met.
  - All counters saturate at 2^CNT_W-1 and never wrap.
  - Idle counter increments when Addr equals the previous PC and stall=0; otherwise it clears. The previous-PC register updates every RUN cycle.
  - Stop conditions, evaluated on each edge:
    - A: Addr==HALT_ADDR.
    - B: IDLE_LIMIT≠0 and the idle counter would reach IDLE_LIMIT.
    - C: TIMEOUT≠0 and Cycle_Cnt+1==TIMEOUT.
  - On any stop condition: counters still update on that edge, state moves to DONE, Status latches the cause.
  - When several conditions hold together, priority is A > B > C.
  - Start is ignored in RUN.
- DONE:
  - Core_En=0 and Core_Clr_N=1, so core state stays visible.
  - Done=1; Status and counters are frozen.
  - Start clears counters, Status and Done on the same edge, and the state moves to HOLD (a full re-sequence).
- Latency:
  - First Core_En=1 is one cycle after the Start edge.
  - Core_En drops on the edge after the stop condition is sampled; Done rises on that same edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Package cpu_run_pkg holds:
  - enum run_state_e {HOLD, WAIT, RUN, DONE};
  - enum stop_cause_e {STOP_NONE=2'b00, STOP_HALT=2'b01, STOP_IDLE=2'b10, STOP_TIMEOUT=2'b11}.
- Sub-module sat_counter (parameter W; ports CLK, CLR_N, clr, inc, q). It is instantiated three times for the performance counters.

Test Plan:
- Reset release: CLR_N low 2 cycles then high, RST_HOLD=2 -> Core_Clr_N low through 2 cycles after release then 1; Core_En stays 0 until Start; all counters 0.
- Halt address: Start, PC sequence 0,4,8..76 with no stalls -> Done=1 and Status=01 on the edge after PC=76 is sampled; Cycle_Cnt=20; Core_En=0.
- Idle detection: IDLE_LIMIT=8, PC held at 40 with stall=1 for 5 cycles then stall=0 -> no stop during the stall cycles; Status=10 after the 8th non-stalled repeat; Stall_Cnt=5.
- Timeout and priority: TIMEOUT=20, PC reaches HALT_ADDR exactly at cycle 20 -> Status=01 (halt address wins), Cycle_Cnt=20.
- Counters: 3 branch pulses and 4 stall cycles during a run -> Branch_Cnt=3, Stall_Cnt=4; CNT_W=4 with a 20-cycle run -> Cycle_Cnt saturates at 15.
- Restart and abort: Start in DONE -> counters and Status clear, HOLD lasts RST_HOLD cycles, then WAIT; CLR_N pulsed low mid-RUN -> all outputs return to reset values asynchronously.
